// File: rtl/rx_block_lock_ctrl.sv
// 64B/66B receive block-lock controller for one GT lane.
// Hunts sync-header alignment with bitslips, then monitors header errors per window.
module rx_block_lock_ctrl #(
    parameter int unsigned P_LOCK_CNT  = 64,
    parameter int unsigned P_WIN_LEN   = 64,
    parameter int unsigned P_BAD_MAX   = 16,
    parameter int unsigned P_SLIP_WAIT = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_gt_ready,
    input  logic [1:0] i_header,
    input  logic       i_header_valid,
    output logic       o_slip,
    output logic       o_block_lock,
    output logic [7:0] o_slip_cnt
);

    localparam int SH_W  = $clog2(P_LOCK_CNT + 1);
    localparam int WIN_W = $clog2(P_WIN_LEN + 1);
    localparam int BAD_W = $clog2(P_BAD_MAX + 1);
    localparam int WT_W  = $clog2(P_SLIP_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TEST,
        S_LOCKED,
        S_SLIP,
        S_SLIP_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [SH_W-1:0]    sh_cnt_q, sh_cnt_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [BAD_W-1:0]   bad_cnt_q, bad_cnt_d;
    logic [WT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic               slip_q, slip_d;
    logic               lock_q, lock_d;
    logic [7:0]         slip_cnt_q, slip_cnt_d;
    logic               good;
    logic               go_slip;

    assign good = i_header[1] ^ i_header[0];

    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        win_cnt_d  = win_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        wait_cnt_d = wait_cnt_q;
        slip_d     = 1'b0;
        lock_d     = lock_q;
        slip_cnt_d = slip_cnt_q;
        go_slip    = 1'b0;

        if (!i_gt_ready) begin
            state_d    = S_IDLE;
            lock_d     = 1'b0;
            sh_cnt_d   = '0;
            win_cnt_d  = '0;
            bad_cnt_d  = '0;
            wait_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sh_cnt_d   = '0;
                    win_cnt_d  = '0;
                    bad_cnt_d  = '0;
                    wait_cnt_d = '0;
                    lock_d     = 1'b0;
                    state_d    = S_TEST;
                end
                S_TEST: begin
                    if (i_header_valid) begin
                        if (!good) begin
                            go_slip = 1'b1;
                        end else if (sh_cnt_q == SH_W'(P_LOCK_CNT - 1)) begin
                            lock_d    = 1'b1;
                            sh_cnt_d  = '0;
                            win_cnt_d = '0;
                            bad_cnt_d = '0;
                            state_d   = S_LOCKED;
                        end else begin
                            sh_cnt_d = sh_cnt_q + SH_W'(1);
                        end
                    end
                end
                S_LOCKED: begin
                    // A bad header that also closes the window still drops lock
                    if (i_header_valid) begin
                        if (!good && bad_cnt_q == BAD_W'(P_BAD_MAX - 1)) begin
                            go_slip = 1'b1;
                            lock_d  = 1'b0;
                        end else if (win_cnt_q == WIN_W'(P_WIN_LEN - 1)) begin
                            win_cnt_d = '0;
                            bad_cnt_d = '0;
                        end else begin
                            win_cnt_d = win_cnt_q + WIN_W'(1);
                            if (!good) begin
                                bad_cnt_d = bad_cnt_q + BAD_W'(1);
                            end
                        end
                    end
                end
                S_SLIP: begin
                    sh_cnt_d   = '0;
                    win_cnt_d  = '0;
                    bad_cnt_d  = '0;
                    wait_cnt_d = '0;
                    state_d    = S_SLIP_WAIT;
                end
                S_SLIP_WAIT: begin
                    if (wait_cnt_q == WT_W'(P_SLIP_WAIT - 1)) begin
                        wait_cnt_d = '0;
                        state_d    = S_TEST;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (go_slip) begin
                state_d   = S_SLIP;
                slip_d    = 1'b1;
                sh_cnt_d  = '0;
                win_cnt_d = '0;
                bad_cnt_d = '0;
                if (slip_cnt_q != 8'hFF) begin
                    slip_cnt_d = slip_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            sh_cnt_q   <= '0;
            win_cnt_q  <= '0;
            bad_cnt_q  <= '0;
            wait_cnt_q <= '0;
            slip_q     <= 1'b0;
            lock_q     <= 1'b0;
            slip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            win_cnt_q  <= win_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            slip_q     <= slip_d;
            lock_q     <= lock_d;
            slip_cnt_q <= slip_cnt_d;
        end
    end

    assign o_slip       = slip_q;
    assign o_block_lock = lock_q;
    assign o_slip_cnt   = slip_cnt_q;

endmodule
